// File: rtl/dram_req_sched.sv
// Request scheduler feeding the DRAM controller FSM: row-hit-biased round-robin
// across requesters, with strict-priority refresh at every idle decision.
module dram_req_sched #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 20,
    parameter int NUM_OF_BANKS   = 8,
    parameter int NUM_OF_ROWS    = 128,
    parameter int MAX_HIT_STREAK = 4
) (
    input  logic                          clk,
    input  logic                          rst_b,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_rw,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          refresh_flag,
    output logic                          refresh_req,
    input  logic                          refresh_ack,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    output logic [ADDR_WIDTH-1:0]         issue_addr,
    output logic                          issue_rw,
    output logic [$clog2(NUM_REQ)-1:0]    issue_src,
    output logic                          issue_row_hit,
    input  logic                          done,
    output logic                          refresh_overrun
);

    localparam int SRC_W    = $clog2(NUM_REQ);
    localparam int BANK_W   = $clog2(NUM_OF_BANKS);
    localparam int ROW_W    = $clog2(NUM_OF_ROWS);
    localparam int COL_W    = 3;
    localparam int ROW_LSB  = COL_W;
    localparam int BANK_LSB = COL_W + ROW_W;
    localparam int STRK_W   = $clog2(MAX_HIT_STREAK + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_BUSY    = 2'd2;
    localparam logic [1:0] ST_REFRESH = 2'd3;

    logic [1:0]                          state_q, state_d;
    logic [SRC_W-1:0]                    rr_ptr_q, rr_ptr_d;
    logic [STRK_W-1:0]                   hit_streak_q, hit_streak_d;
    logic [NUM_OF_BANKS-1:0]             open_vld_q, open_vld_d;
    logic [NUM_OF_BANKS-1:0][ROW_W-1:0]  open_row_q, open_row_d;
    logic                                refresh_pending_q, refresh_pending_d;
    logic                                refresh_overrun_q, refresh_overrun_d;
    logic                                refresh_req_q, refresh_req_d;
    logic [NUM_REQ-1:0]                  req_ready_q, req_ready_d;
    logic                                issue_valid_q, issue_valid_d;
    logic [ADDR_WIDTH-1:0]               issue_addr_q, issue_addr_d;
    logic                                issue_rw_q, issue_rw_d;
    logic [SRC_W-1:0]                    issue_src_q, issue_src_d;
    logic                                issue_row_hit_q, issue_row_hit_d;

    logic [NUM_REQ-1:0][BANK_W-1:0]      req_bank;
    logic [NUM_REQ-1:0][ROW_W-1:0]       req_row;
    logic [NUM_REQ-1:0]                  req_hit;
    logic [NUM_REQ-1:0]                  cand;
    logic                                use_hits;
    logic                                grant_found;
    logic [SRC_W-1:0]                    grant_idx;
    logic [SRC_W-1:0]                    rr_idx;
    logic                                grant_hit;
    logic                                ack_take;
    logic [BANK_W-1:0]                   issue_bank;

    always_comb begin
        req_bank = '0;
        req_row  = '0;
        req_hit  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_bank[i] = req_addr[i*ADDR_WIDTH + BANK_LSB +: BANK_W];
            req_row[i]  = req_addr[i*ADDR_WIDTH + ROW_LSB +: ROW_W];
            req_hit[i]  = req_valid[i] && open_vld_q[req_bank[i]] &&
                          (open_row_q[req_bank[i]] == req_row[i]);
        end
    end

    // Scan candidates starting at rr_ptr, wrapping, so the first match wins.
    always_comb begin
        use_hits    = (|req_hit) && (hit_streak_q < STRK_W'(MAX_HIT_STREAK));
        cand        = use_hits ? req_hit : req_valid;
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_idx      = rr_ptr_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && cand[rr_idx]) begin
                grant_found = 1'b1;
                grant_idx   = rr_idx;
            end
            rr_idx = (rr_idx == SRC_W'(NUM_REQ - 1)) ? '0 : rr_idx + 1'b1;
        end
        grant_hit = req_hit[grant_idx];
    end

    assign issue_bank = issue_addr_q[BANK_LSB +: BANK_W];
    assign ack_take   = (state_q == ST_REFRESH) && refresh_ack;

    always_comb begin
        state_d           = state_q;
        rr_ptr_d          = rr_ptr_q;
        hit_streak_d      = hit_streak_q;
        open_vld_d        = open_vld_q;
        open_row_d        = open_row_q;
        refresh_req_d     = refresh_req_q;
        req_ready_d       = '0;
        issue_valid_d     = issue_valid_q;
        issue_addr_d      = issue_addr_q;
        issue_rw_d        = issue_rw_q;
        issue_src_d       = issue_src_q;
        issue_row_hit_d   = issue_row_hit_q;
        // A flag coinciding with the ack queues a fresh refresh rather than overrunning.
        refresh_pending_d = (refresh_pending_q && !ack_take) || refresh_flag;
        refresh_overrun_d = refresh_overrun_q ||
                            (refresh_flag && refresh_pending_q && !ack_take);

        case (state_q)
            ST_IDLE: begin
                if (refresh_pending_q) begin
                    state_d       = ST_REFRESH;
                    refresh_req_d = 1'b1;
                end else if (grant_found) begin
                    state_d                = ST_ISSUE;
                    req_ready_d[grant_idx] = 1'b1;
                    issue_valid_d          = 1'b1;
                    issue_addr_d           = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    issue_rw_d             = req_rw[grant_idx];
                    issue_src_d            = grant_idx;
                    issue_row_hit_d        = grant_hit;
                    rr_ptr_d = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    if (!grant_hit) begin
                        hit_streak_d = '0;
                    end else if (hit_streak_q != STRK_W'(MAX_HIT_STREAK)) begin
                        hit_streak_d = hit_streak_q + 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (issue_ready) begin
                    state_d                = ST_BUSY;
                    issue_valid_d          = 1'b0;
                    open_vld_d[issue_bank] = 1'b1;
                    open_row_d[issue_bank] = issue_addr_q[ROW_LSB +: ROW_W];
                end
            end
            ST_BUSY: begin
                if (done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_REFRESH: begin
                if (refresh_ack) begin
                    state_d       = ST_IDLE;
                    refresh_req_d = 1'b0;
                    open_vld_d    = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q           <= ST_IDLE;
            rr_ptr_q          <= '0;
            hit_streak_q      <= '0;
            open_vld_q        <= '0;
            open_row_q        <= '0;
            refresh_pending_q <= 1'b0;
            refresh_overrun_q <= 1'b0;
            refresh_req_q     <= 1'b0;
            req_ready_q       <= '0;
            issue_valid_q     <= 1'b0;
            issue_addr_q      <= '0;
            issue_rw_q        <= 1'b0;
            issue_src_q       <= '0;
            issue_row_hit_q   <= 1'b0;
        end else begin
            state_q           <= state_d;
            rr_ptr_q          <= rr_ptr_d;
            hit_streak_q      <= hit_streak_d;
            open_vld_q        <= open_vld_d;
            open_row_q        <= open_row_d;
            refresh_pending_q <= refresh_pending_d;
            refresh_overrun_q <= refresh_overrun_d;
            refresh_req_q     <= refresh_req_d;
            req_ready_q       <= req_ready_d;
            issue_valid_q     <= issue_valid_d;
            issue_addr_q      <= issue_addr_d;
            issue_rw_q        <= issue_rw_d;
            issue_src_q       <= issue_src_d;
            issue_row_hit_q   <= issue_row_hit_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign refresh_req     = refresh_req_q;
    assign issue_valid     = issue_valid_q;
    assign issue_addr      = issue_addr_q;
    assign issue_rw        = issue_rw_q;
    assign issue_src       = issue_src_q;
    assign issue_row_hit   = issue_row_hit_q;
    assign refresh_overrun = refresh_overrun_q;

endmodule

// File: tb/tb_dram_req_sched.sv
// Scoreboard bench for dram_req_sched: directed requests push expected issues,
// a monitor pops and compares on every issue handshake.
module tb_dram_req_sched;

    localparam int NUM_REQ = 4;
    localparam int AW      = 20;

    logic                    clk = 1'b0;
    logic                    rst_b = 1'b0;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_rw;
    logic [NUM_REQ*AW-1:0]   req_addr;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    refresh_flag;
    logic                    refresh_req;
    logic                    refresh_ack;
    logic                    issue_valid;
    logic                    issue_ready;
    logic [AW-1:0]           issue_addr;
    logic                    issue_rw;
    logic [1:0]              issue_src;
    logic                    issue_row_hit;
    logic                    done;
    logic                    refresh_overrun;

    dram_req_sched #(
        .NUM_REQ(4), .ADDR_WIDTH(20), .NUM_OF_BANKS(8), .NUM_OF_ROWS(128), .MAX_HIT_STREAK(4)
    ) dut (
        .clk(clk), .rst_b(rst_b), .req_valid(req_valid), .req_rw(req_rw),
        .req_addr(req_addr), .req_ready(req_ready), .refresh_flag(refresh_flag),
        .refresh_req(refresh_req), .refresh_ack(refresh_ack), .issue_valid(issue_valid),
        .issue_ready(issue_ready), .issue_addr(issue_addr), .issue_rw(issue_rw),
        .issue_src(issue_src), .issue_row_hit(issue_row_hit), .done(done),
        .refresh_overrun(refresh_overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    src;
        logic [AW-1:0] addr;
        logic          rw;
        logic          hit;
    } exp_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          rw;
    } txn_t;

    exp_t exp_q[$];
    txn_t rq[NUM_REQ][$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int last_hs = 0;
    bit spacing_en = 0;
    bit have_last = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [AW-1:0] mk(input int bank, input int row, input int col);
        return {7'd0, 3'(bank), 7'(row), 3'(col)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic push(input int src, input int bank, input int row, input int col,
                        input logic rw, input logic hit);
        txn_t t;
        exp_t e;
        t.addr = mk(bank, row, col);
        t.rw   = rw;
        e.src  = 2'(src);
        e.addr = t.addr;
        e.rw   = rw;
        e.hit  = hit;
        rq[src].push_back(t);
        exp_q.push_back(e);
    endtask

    function automatic bit rq_busy();
        for (int i = 0; i < NUM_REQ; i++)
            if (rq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit cond(input int which, input int base);
        case (which)
            0:       return issue_valid === 1'b1;
            1:       return refresh_req === 1'b1;
            default: return hs_cnt > base;
        endcase
    endfunction

    task automatic wait_for(input string name, input int which, input int base);
        int n = 0;
        while (!cond(which, base) && n < 50) begin
            tick();
            n++;
        end
        if (!cond(which, base)) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s got=none want=event", name);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || rq_busy()) && n < 300) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0 || rq_busy()) begin
            checks++;
            errors++;
            $display("FAIL drain_%s got=%0d pending want=0", name, exp_q.size());
            exp_q.delete();
            for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
        end
        repeat (4) tick();
    endtask

    // Requester model: hold the head transaction until its req_ready is seen.
    initial begin
        req_valid = '0;
        req_rw    = '0;
        req_addr  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && rq[i].size() != 0) void'(rq[i].pop_front());
                if (rq[i].size() != 0) begin
                    req_valid[i]          = 1'b1;
                    req_rw[i]             = rq[i][0].rw;
                    req_addr[i*AW +: AW]  = rq[i][0].addr;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    initial begin
        exp_t e;
        logic prev_iv = 1'b0;
        logic [3:0] one = 4'b0001;
        forever begin
            @(negedge clk);
            if (rst_b) begin
                if (issue_valid && !prev_iv) begin
                    checks++;
                    if (req_ready !== (one << issue_src)) begin
                        errors++;
                        $display("FAIL req_ready_pulse got=%b want=%b", req_ready, one << issue_src);
                    end
                end
                if (issue_valid && issue_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_issue got src=%0d addr=%h want=none",
                                 issue_src, issue_addr);
                    end else begin
                        e = exp_q.pop_front();
                        if ({issue_src, issue_addr, issue_rw, issue_row_hit} !== e) begin
                            errors++;
                            $display("FAIL issue got src=%0d addr=%h rw=%0b hit=%0b want src=%0d addr=%h rw=%0b hit=%0b",
                                     issue_src, issue_addr, issue_rw, issue_row_hit,
                                     e.src, e.addr, e.rw, e.hit);
                        end
                    end
                    if (spacing_en) begin
                        if (have_last) begin
                            checks++;
                            if (cyc - last_hs != 3) begin
                                errors++;
                                $display("FAIL grant_spacing got=%0d want=3", cyc - last_hs);
                            end
                        end
                        have_last = 1'b1;
                        last_hs   = cyc;
                    end
                    hs_cnt++;
                end
            end
            prev_iv = issue_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int extra;
        issue_ready  = 1'b1;
        done         = 1'b1;
        refresh_flag = 1'b0;
        refresh_ack  = 1'b0;

        repeat (2) tick();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_refresh_req", 32'(refresh_req), 0);
        chk("rst_issue_valid", 32'(issue_valid), 0);
        chk("rst_issue_addr", 32'(issue_addr), 0);
        chk("rst_issue_rw", 32'(issue_rw), 0);
        chk("rst_issue_src", 32'(issue_src), 0);
        chk("rst_issue_row_hit", 32'(issue_row_hit), 0);
        chk("rst_overrun", 32'(refresh_overrun), 0);
        rst_b = 1'b1;
        tick();

        // All four requesters, banks closed: plain round-robin at 3-cycle spacing
        spacing_en = 1'b1;
        have_last  = 1'b0;
        push(0, 0, 1, 0, 1'b0, 1'b0);
        push(1, 1, 1, 0, 1'b1, 1'b0);
        push(2, 2, 1, 0, 1'b0, 1'b0);
        push(3, 3, 1, 0, 1'b1, 1'b0);
        push(0, 4, 2, 0, 1'b0, 1'b0);
        wait_drain("rr_pass");
        spacing_en = 1'b0;

        // Row hit beats round-robin pointer (rr_ptr=2 when req1/req2 compete)
        push(0, 2, 5, 0, 1'b1, 1'b0);
        wait_drain("open_b2");
        push(1, 6, 3, 1, 1'b0, 1'b0);
        wait_drain("rr_to_2");
        push(1, 2, 5, 2, 1'b0, 1'b1);
        push(2, 3, 9, 3, 1'b1, 1'b0);
        wait_drain("hit_first");

        // Hit streak: four req0 hits, req3 miss, then hits resume
        push(0, 1, 7, 0, 1'b0, 1'b0);
        wait_drain("open_b1");
        push(0, 1, 7, 1, 1'b0, 1'b1);
        push(0, 1, 7, 2, 1'b1, 1'b1);
        push(0, 1, 7, 3, 1'b0, 1'b1);
        push(0, 1, 7, 4, 1'b1, 1'b1);
        push(3, 5, 10, 0, 1'b1, 1'b0);
        push(0, 1, 7, 5, 1'b0, 1'b1);
        push(0, 1, 7, 6, 1'b1, 1'b1);
        wait_drain("streak");

        // Refresh flagged during BUSY: access completes, then refresh closes all banks
        done = 1'b0;
        base = hs_cnt;
        push(2, 1, 7, 0, 1'b1, 1'b1);
        push(2, 1, 7, 1, 1'b0, 1'b0);
        wait_for("busy", 2, base);
        refresh_flag = 1'b1;
        tick();
        refresh_flag = 1'b0;
        repeat (3) begin
            tick();
            chk("no_preempt_refresh_req", 32'(refresh_req), 0);
        end
        chk("no_preempt_issue_valid", 32'(issue_valid), 0);
        done = 1'b1;
        tick();
        done = 1'b0;
        wait_for("refresh_req", 1, 0);
        repeat (3) begin
            tick();
            chk("refresh_req_hold", 32'(refresh_req), 1);
            chk("no_issue_in_refresh", 32'(issue_valid), 0);
        end
        refresh_ack = 1'b1;
        tick();
        refresh_ack = 1'b0;
        chk("refresh_req_drop", 32'(refresh_req), 0);
        done = 1'b1;
        wait_drain("after_refresh");
        chk("no_overrun_single", 32'(refresh_overrun), 0);

        // Two flags while stalled in ISSUE: sticky overrun, one refresh
        issue_ready = 1'b0;
        push(1, 0, 3, 0, 1'b1, 1'b0);
        wait_for("stall_issue", 0, 0);
        refresh_flag = 1'b1;
        tick();
        refresh_flag = 1'b0;
        chk("overrun_first_flag", 32'(refresh_overrun), 0);
        tick();
        tick();
        refresh_flag = 1'b1;
        tick();
        refresh_flag = 1'b0;
        chk("overrun_second_flag", 32'(refresh_overrun), 1);
        chk("still_stalled", 32'(issue_valid), 1);
        issue_ready = 1'b1;
        wait_for("refresh2", 1, 0);
        refresh_ack = 1'b1;
        tick();
        refresh_ack = 1'b0;
        extra = 0;
        repeat (6) begin
            tick();
            if (refresh_req) extra++;
        end
        chk("single_refresh", 32'(extra), 0);
        chk("overrun_sticky", 32'(refresh_overrun), 1);
        wait_drain("overrun");

        // Reset mid-ISSUE: outputs clear asynchronously
        issue_ready = 1'b0;
        rq[1].push_back('{addr: mk(7, 1, 0), rw: 1'b0});
        wait_for("rst_issue", 0, 0);
        tick();
        #2;
        rst_b = 1'b0;
        #1;
        chk("arst_issue_valid", 32'(issue_valid), 0);
        chk("arst_req_ready", 32'(req_ready), 0);
        chk("arst_issue_addr", 32'(issue_addr), 0);
        chk("arst_issue_src", 32'(issue_src), 0);
        chk("arst_issue_rw_hit", 32'({issue_rw, issue_row_hit}), 0);
        chk("arst_overrun", 32'(refresh_overrun), 0);
        for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
        issue_ready = 1'b1;
        repeat (2) tick();
        rst_b = 1'b1;
        tick();

        // Reset mid-REFRESH
        refresh_flag = 1'b1;
        tick();
        refresh_flag = 1'b0;
        wait_for("rst_refresh", 1, 0);
        tick();
        #2;
        rst_b = 1'b0;
        #1;
        chk("arst_refresh_req", 32'(refresh_req), 0);
        chk("arst_ref_issue_valid", 32'(issue_valid), 0);
        repeat (2) tick();
        rst_b = 1'b1;
        tick();

        // First grant after reset goes to requester 0
        push(0, 4, 11, 0, 1'b0, 1'b0);
        push(1, 5, 12, 0, 1'b1, 1'b0);
        push(2, 6, 13, 0, 1'b0, 1'b0);
        push(3, 7, 14, 0, 1'b1, 1'b0);
        wait_drain("post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
